// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full adder plus a registered carry, LSB first,
// one bit per clock under a start/done handshake with held results.

module FA (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic sum,
   output logic co
);
   assign sum = a ^ b ^ ci;
   assign co  = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         co,
   output logic         ovf
);
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   sa_q, sa_d;
   logic [N-1:0]   sb_q, sb_d;
   logic [N-1:0]   ps_q, ps_d;
   logic           c_q, c_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   sum_q, sum_d;
   logic           co_q, co_d;
   logic           ovf_q, ovf_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           fa_s;
   logic           fa_co;
   logic [N-1:0]   ps_shift;

   FA u_fa (
      .a   (sa_q[0]),
      .b   (sb_q[0]),
      .ci  (c_q),
      .sum (fa_s),
      .co  (fa_co)
   );

   // New sum bit enters at the MSB so the LSB lands at bit 0 after N shifts.
   assign ps_shift = (ps_q >> 1) | (N'(fa_s) << (N - 1));

   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      ps_d    = ps_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               c_d     = ci;
               ps_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sa_d  = sa_q >> 1;
            sb_d  = sb_q >> 1;
            ps_d  = ps_shift;
            c_d   = fa_co;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               sum_d   = ps_shift;
               co_d    = fa_co;
               ovf_d   = c_q ^ fa_co;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         ps_q    <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ps_q    <= ps_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign co   = co_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands
// against an arithmetic reference model.

module tb_serial_adder;
   localparam int unsigned N  = 8;
   localparam int unsigned W1 = N + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] a, b;
   logic         ci;
   logic         busy, done;
   logic [N-1:0] sum;
   logic         co, ovf;

   int n_checks = 0;
   int n_fail   = 0;

   logic [N-1:0] exp_sum = '0;
   logic         exp_co  = 1'b0;
   logic         exp_ovf = 1'b0;

   serial_adder #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .co    (co),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives start at the current negedge and follows the operation to done.
   // If poke > 0, start is pulsed with 1+1 after that many edges (while busy).
   task automatic op(input logic [N-1:0] oa, input logic [N-1:0] ob, input logic oci,
                     input int poke, input string tag);
      logic [N:0] full;
      logic       m_ovf;
      int         lat;
      int         busy_cnt;
      full  = {1'b0, oa} + {1'b0, ob} + W1'(oci);
      m_ovf = (oa[N-1] == ob[N-1]) && (full[N-1] != oa[N-1]);
      start = 1'b1; a = oa; b = ob; ci = oci;
      lat = 0; busy_cnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (poke > 0 && lat == poke) begin
            start = 1'b1; a = N'(1); b = N'(1); ci = 1'b0;
         end else begin
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (lat == 1) begin
            chk({tag, " held_sum"}, 32'(sum), 32'(exp_sum));
            chk({tag, " held_co"},  32'(co),  32'(exp_co));
         end
      end while (!done && lat < 60);
      start = 1'b0;
      chk({tag, " latency"},  32'(lat),      32'(N + 1));
      chk({tag, " busy_cnt"}, 32'(busy_cnt), 32'(N));
      exp_sum = full[N-1:0];
      exp_co  = full[N];
      exp_ovf = m_ovf;
      chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
      chk({tag, " co"},  32'(co),  32'(exp_co));
      chk({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
   endtask

   task automatic check_quiet(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         chk({tag, " done"}, 32'(done), 32'(0));
         chk({tag, " busy"}, 32'(busy), 32'(0));
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst busy", 32'(busy), 32'(0));
      chk("rst done", 32'(done), 32'(0));
      chk("rst sum",  32'(sum),  32'(0));
      chk("rst co",   32'(co),   32'(0));
      chk("rst ovf",  32'(ovf),  32'(0));
      reset = 1'b0;

      op(8'h5A, 8'h3C, 1'b0, 0, "basic");
      check_quiet("after_basic", 1);
      op(8'hFF, 8'h01, 1'b0, 0, "wrap");
      op(8'h7F, 8'h00, 1'b1, 0, "cin");
      op(8'h80, 8'h80, 1'b0, 0, "negneg");
      op(8'h10, 8'h20, 1'b0, 3, "busy_start");
      check_quiet("no_restart", 3);
      chk("no_restart sum", 32'(sum), 32'(8'h30));

      // Abort mid-run: async reset clears outputs without waiting for an edge.
      start = 1'b1; a = 8'h77; b = 8'h11; ci = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid busy_pre", 32'(busy), 32'(1));
      reset = 1'b1;
      #1;
      chk("mid busy", 32'(busy), 32'(0));
      chk("mid done", 32'(done), 32'(0));
      chk("mid sum",  32'(sum),  32'(0));
      chk("mid co",   32'(co),   32'(0));
      chk("mid ovf",  32'(ovf),  32'(0));
      exp_sum = '0; exp_co = 1'b0; exp_ovf = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_quiet("post_rst", 10);
      op(8'h03, 8'h04, 1'b0, 0, "after_rst");

      // Back-to-back: start issued in the DONE cycle, no IDLE gap.
      op(8'h12, 8'h34, 1'b0, 0, "b2b_first");
      op(8'hAA, 8'h55, 1'b0, 0, "b2b_second");

      for (int i = 0; i < 20; i++) begin
         op(N'($urandom), N'($urandom), 1'($urandom), 0, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end
endmodule
